// File: rtl/lms_fifo_rd_pkg.sv
// Shared types and helpers for the LMS FIFO read-side framer.
// Holds the FSM state encoding, legal parameter ranges and counter sizing.
package lms_fifo_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    localparam int RD_LATENCY_MIN   = 1;
    localparam int RD_LATENCY_MAX   = 2;
    localparam int BUF_DEPTH_MARGIN = 2;
    localparam int FRAME_LEN_MIN    = 2;
    localparam int FRAME_LEN_MAX    = 65535;

    // Width of a counter that must be able to hold max_value itself.
    function automatic int cnt_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/lms_fifo_rd_framer_if.sv
// FIFO read port plus framed valid/ready sample stream of the LMS read framer.
// The master modport is the framer; the slave modport is the FIFO/consumer side.
interface lms_fifo_rd_framer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  empty;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output rd_en,
        input  rd_data,
        input  empty,
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  rd_en,
        output rd_data,
        output empty,
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/lms_fifo_rd_skid.sv
// Small circular skid buffer that absorbs the FIFO read latency.
// The head entry is presented directly, so the output holds while not popped.
module lms_fifo_rd_skid
    import lms_fifo_rd_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 4,
    localparam int CNT_W      = cnt_width(DEPTH)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic [CNT_W-1:0]      o_count
);
    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_C   = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_pop;

    assign w_pop = i_pop && (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            if (i_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

    // The upstream credit check must make a push into a full buffer impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && !w_pop && (r_count == FULL_C)));

endmodule

// File: rtl/lms_fifo_rd_framer.sv
// Read-side drain engine: pops the LMS FIFO, absorbs read latency, frames samples.
// Define LMS_FIFO_RD_UNDERRUN_CNT_EN to build the saturating starved-cycle counter.
module lms_fifo_rd_framer
    import lms_fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int FRAME_LEN  = 256,
    parameter int BUF_DEPTH  = 4
)(
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    input  logic                 en,
    lms_fifo_rd_framer_if.master bus,
    output logic                 frame_done,
    output logic                 busy,
    output logic [15:0]          underrun_cnt
);
    localparam int               CNT_W       = cnt_width(FRAME_LEN);
    localparam int               OCC_W       = cnt_width(BUF_DEPTH);
    localparam int               CREDIT_W    = OCC_W + 1;
    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_C      = CNT_W'(FRAME_LEN - 1);
    localparam logic [CREDIT_W-1:0] CREDIT_C = CREDIT_W'(BUF_DEPTH);

    if ((RD_LATENCY < RD_LATENCY_MIN) || (RD_LATENCY > RD_LATENCY_MAX) ||
        (BUF_DEPTH < RD_LATENCY + BUF_DEPTH_MARGIN) ||
        (FRAME_LEN < FRAME_LEN_MIN) || (FRAME_LEN > FRAME_LEN_MAX)) begin : g_param_error
        $error("lms_fifo_rd_framer: illegal parameter combination");
    end

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_issued;
    logic [CNT_W-1:0]      r_delivered;
    logic [RD_LATENCY-1:0] r_tags;
    logic                  r_frame_done;
    logic [OCC_W-1:0]      w_inflight;
    logic [OCC_W-1:0]      w_occ;
    logic [CREDIT_W-1:0]   w_credit_used;
    logic                  w_credit_ok;
    logic                  w_rd_en;
    logic                  w_start;
    logic                  w_frame_done_set;
    logic                  w_out_valid;
    logic [DATA_WIDTH-1:0] w_out_data;
    logic                  w_handshake;
    logic                  w_last;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + OCC_W'(r_tags[i]);
        end
    end

    // Words already requested count against the buffer so a late arrival always fits.
    assign w_credit_used = {1'b0, w_inflight} + {1'b0, w_occ};
    assign w_credit_ok   = (w_credit_used < CREDIT_C);
    assign w_handshake   = w_out_valid && bus.out_ready;
    assign w_last        = (r_delivered == LAST_C);

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_rd_en          = 1'b0;
        w_start          = 1'b0;
        w_frame_done_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en && !bus.empty) begin
                    w_next_state = ST_STREAM;
                    w_start      = 1'b1;
                end
            end
            ST_STREAM: begin
                w_rd_en = !bus.empty && (r_issued < FRAME_LEN_C) && w_credit_ok;
                if (w_rd_en && (r_issued == LAST_C)) begin
                    w_next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_handshake && w_last) begin
                    w_next_state     = ST_IDLE;
                    w_frame_done_set = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Tag pipe mirrors the FIFO read latency; its tail marks rd_data as valid.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_issued     <= '0;
            r_delivered  <= '0;
            r_tags       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_tags       <= (r_tags << 1) | RD_LATENCY'(w_rd_en);
            r_frame_done <= w_frame_done_set;
            if (w_start) begin
                r_issued    <= '0;
                r_delivered <= '0;
            end else begin
                if (w_rd_en) begin
                    r_issued <= r_issued + 1'b1;
                end
                if (w_handshake) begin
                    r_delivered <= r_delivered + 1'b1;
                end
            end
        end
    end

    lms_fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_skid (
        .clk     (rd_clk),
        .rst     (rd_rst),
        .i_push  (r_tags[RD_LATENCY-1]),
        .i_data  (bus.rd_data),
        .i_pop   (w_handshake),
        .o_data  (w_out_data),
        .o_valid (w_out_valid),
        .o_count (w_occ)
    );

`ifdef LMS_FIFO_RD_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_underrun_cnt <= '0;
        end else if ((r_state == ST_STREAM) && !w_out_valid && bus.empty &&
                     (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 1'b1;
        end
    end

    assign underrun_cnt = r_underrun_cnt;
`else
    assign underrun_cnt = '0;
`endif

    assign bus.rd_en     = w_rd_en;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.out_last  = w_out_valid && w_last;
    assign frame_done    = r_frame_done;
    assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lms_fifo_rd_framer.sv
// Bench for lms_fifo_rd_framer: queue-based FIFO harness plus a cycle reference model.
// Honours LMS_FIFO_RD_UNDERRUN_CNT_EN for the expected underrun count.
module tb_lms_fifo_rd_framer;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int FL  = 8;
    localparam int BD  = 4;

    logic        rd_clk = 1'b0;
    logic        rd_rst;
    logic        en;
    logic        frame_done;
    logic        busy;
    logic [15:0] underrun_cnt;

    lms_fifo_rd_framer_if #(.DATA_WIDTH(DW)) bus ();

    lms_fifo_rd_framer #(
        .DATA_WIDTH (DW),
        .RD_LATENCY (LAT),
        .FRAME_LEN  (FL),
        .BUF_DEPTH  (BD)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .en           (en),
        .bus          (bus.master),
        .frame_done   (frame_done),
        .busy         (busy),
        .underrun_cnt (underrun_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    int assertCount = 0;
    int failCount   = 0;

    logic [DW-1:0] fifoQ[$];
    logic [DW-1:0] srcQ[$];
    logic [DW-1:0] mBuf[$];
    logic [DW-1:0] popVal[$];
    int            popCyc[$];
    logic [DW-1:0] pipe[LAT];
    int            mState;
    int            mIssued;
    int            mDelivered;
    bit            mDone;
    int            mUnder;
    int            cyc = 0;
    int unsigned   wordCtr = 0;

    logic          expRdEn, expValid, expLast, expBusy, expDone;
    logic [DW-1:0] expData;
    logic [15:0]   expUnder;

    logic          sRdEn = 1'b0;
    bit            chkEn = 1'b0;
    logic [DW-1:0] gotData[$];
    bit            gotLast[$];
    int            firstRdCyc = -1;
    int            firstValidCyc = -1;
    int            rdEnCount = 0;
    int            doneCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic modelReset();
        mBuf.delete();
        popVal.delete();
        popCyc.delete();
        mState     = 0;
        mIssued    = 0;
        mDelivered = 0;
        mDone      = 1'b0;
        mUnder     = 0;
    endtask

    // Advance the reference model over the cycle that just ended.
    task automatic modelUpdate();
        bit            hs;
        logic [DW-1:0] tmpData;
        int            tmpCyc;
        if (rd_rst) begin
            modelReset();
            return;
        end
        hs    = expValid && bus.out_ready;
        mDone = 1'b0;
        if (hs) begin
            tmpData = mBuf.pop_front();
            mDelivered++;
        end
        if (expRdEn) begin
            popCyc.push_back(cyc);
            popVal.push_back((srcQ.size() > 0) ? srcQ.pop_front() : 'x);
            mIssued++;
        end
        if (popCyc.size() > 0 && popCyc[0] + LAT == cyc) begin
            mBuf.push_back(popVal.pop_front());
            tmpCyc = popCyc.pop_front();
        end
`ifdef LMS_FIFO_RD_UNDERRUN_CNT_EN
        if (mState == 1 && !expValid && bus.empty && mUnder < 65535) mUnder++;
`endif
        case (mState)
            0: if (en && !bus.empty) begin
                mState     = 1;
                mIssued    = 0;
                mDelivered = 0;
            end
            1: if (mIssued == FL) mState = 2;
            default: if (hs && expLast) begin
                mState = 0;
                mDone  = 1'b1;
            end
        endcase
    endtask

    task automatic computeExpected();
        if (rd_rst) begin
            expRdEn  = 1'b0;
            expValid = 1'b0;
            expLast  = 1'b0;
            expBusy  = 1'b0;
            expDone  = 1'b0;
            expData  = '0;
            expUnder = '0;
        end else begin
            expValid = (mBuf.size() > 0);
            expData  = expValid ? mBuf[0] : '0;
            expLast  = expValid && (mDelivered == FL - 1);
            expRdEn  = (mState == 1) && !bus.empty && (mIssued < FL) &&
                       ((popCyc.size() + mBuf.size()) < BD);
            expBusy  = (mState != 0);
            expDone  = mDone;
            expUnder = 16'(mUnder);
        end
    endtask

    task automatic writeWords(input int n);
        for (int i = 0; i < n; i++) begin
            fifoQ.push_back(DW'(wordCtr));
            srcQ.push_back(DW'(wordCtr));
            wordCtr++;
        end
    endtask

    // One clock: update model and FIFO harness, then drive this cycle's inputs.
    task automatic applyStimulus(input bit enV, input bit readyV, input int nWrite, input bit rstV);
        @(posedge rd_clk);
        #1;
        modelUpdate();
        cyc++;
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = (sRdEn && fifoQ.size() > 0) ? fifoQ.pop_front() : DW'($urandom);
        en            = enV;
        bus.out_ready = readyV;
        rd_rst        = rstV;
        if (rstV) begin
            modelReset();
            fifoQ.delete();
            srcQ.delete();
            pipe = '{default: '0};
        end
        writeWords(nWrite);
        bus.empty   = (fifoQ.size() == 0);
        bus.rd_data = pipe[LAT-1];
        computeExpected();
    endtask

    always @(negedge rd_clk) begin
        sRdEn = bus.rd_en;
        if (chkEn) begin
            checkOutput("rd_en", 32'(bus.rd_en), 32'(expRdEn));
            checkOutput("out_valid", 32'(bus.out_valid), 32'(expValid));
            checkOutput("out_last", 32'(bus.out_last), 32'(expLast));
            if (expValid || rd_rst) checkOutput("out_data", bus.out_data, expData);
            checkOutput("frame_done", 32'(frame_done), 32'(expDone));
            checkOutput("busy", 32'(busy), 32'(expBusy));
            checkOutput("underrun_cnt", 32'(underrun_cnt), 32'(expUnder));
            if (!rd_rst && bus.out_valid && bus.out_ready) begin
                gotData.push_back(bus.out_data);
                gotLast.push_back(bus.out_last);
            end
            if (bus.rd_en) rdEnCount++;
            if (bus.rd_en && firstRdCyc < 0) firstRdCyc = cyc;
            if (bus.out_valid && firstValidCyc < 0) firstValidCyc = cyc;
            if (frame_done) doneCount++;
        end
    end

    task automatic clearRecords();
        gotData.delete();
        gotLast.delete();
        firstRdCyc    = -1;
        firstValidCyc = -1;
        rdEnCount     = 0;
        doneCount     = 0;
    endtask

    initial begin
        int          tStart;
        int          budget;
        logic [15:0] underBefore;
        rd_rst        = 1'b1;
        en            = 1'b0;
        bus.out_ready = 1'b0;
        bus.empty     = 1'b1;
        bus.rd_data   = '0;
        pipe          = '{default: '0};
        modelReset();
        computeExpected();
        chkEn = 1'b1;

        repeat (3) applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkOutput("reset_rd_en", 32'(bus.rd_en), 32'd0);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_out_data", bus.out_data, 32'd0);
        checkOutput("reset_underrun", 32'(underrun_cnt), 32'd0);
        repeat (2) applyStimulus(1'b0, 1'b1, 0, 1'b0);

        $display("[TB] steady stream");
        clearRecords();
        applyStimulus(1'b1, 1'b1, 16, 1'b0);
        tStart = cyc;
        budget = 0;
        while (doneCount < 2 && budget < 100) begin
            applyStimulus(1'b1, 1'b1, 0, 1'b0);
            budget++;
        end
        checkOutput("steady_frames", 32'(doneCount), 32'd2);
        checkOutput("steady_start", 32'(firstRdCyc - tStart), 32'd1);
        checkOutput("steady_latency", 32'(firstValidCyc - firstRdCyc), 32'(LAT + 1));
        checkOutput("steady_count", 32'(gotData.size()), 32'd16);
        for (int i = 0; i < gotData.size(); i++) begin
            checkOutput("steady_data", gotData[i], 32'(i));
            checkOutput("steady_last", 32'(gotLast[i]), 32'((i % FL) == FL - 1));
        end

        $display("[TB] backpressure");
        clearRecords();
        applyStimulus(1'b1, 1'b0, 24, 1'b0);
        repeat (12) applyStimulus(1'b1, 1'b0, 0, 1'b0);
        checkOutput("credit_pops", 32'(rdEnCount), 32'(BD));
        budget = 0;
        while (doneCount < 3 && budget < 300) begin
            applyStimulus(1'b1, (budget % 4 == 0) || (budget % 4 == 3), 0, 1'b0);
            budget++;
        end
        checkOutput("bp_frames", 32'(doneCount), 32'd3);
        checkOutput("bp_count", 32'(gotData.size()), 32'd24);
        for (int i = 0; i < gotData.size(); i++) begin
            checkOutput("bp_data", gotData[i], 32'(16 + i));
        end

        $display("[TB] starvation");
        clearRecords();
        underBefore = underrun_cnt;
        applyStimulus(1'b1, 1'b1, 3, 1'b0);
        repeat (20) applyStimulus(1'b1, 1'b1, 0, 1'b0);
        checkOutput("starve_busy", 32'(busy), 32'd1);
        applyStimulus(1'b1, 1'b1, 5, 1'b0);
        budget = 0;
        while (doneCount < 1 && budget < 100) begin
            applyStimulus(1'b0, 1'b1, 0, 1'b0);
            budget++;
        end
        checkOutput("starve_frames", 32'(doneCount), 32'd1);
        checkOutput("starve_count", 32'(gotData.size()), 32'd8);
        if (gotData.size() == 8) checkOutput("starve_last8", 32'(gotLast[7]), 32'd1);
`ifdef LMS_FIFO_RD_UNDERRUN_CNT_EN
        checkOutput("starve_underrun_ge9", 32'((underrun_cnt - underBefore) >= 16'd9), 32'd1);
`else
        checkOutput("starve_underrun_zero", 32'(underrun_cnt), 32'd0);
`endif

        $display("[TB] enable drop");
        clearRecords();
        applyStimulus(1'b1, 1'b1, 16, 1'b0);
        budget = 0;
        while (doneCount < 1 && budget < 100) begin
            applyStimulus(gotData.size() < 3, 1'b1, 0, 1'b0);
            budget++;
        end
        checkOutput("endrop_frames", 32'(doneCount), 32'd1);
        rdEnCount = 0;
        repeat (10) applyStimulus(1'b0, 1'b1, 0, 1'b0);
        checkOutput("endrop_no_rd_en", 32'(rdEnCount), 32'd0);
        checkOutput("endrop_busy", 32'(busy), 32'd0);
        checkOutput("endrop_left", 32'(fifoQ.size()), 32'd8);

        $display("[TB] reset mid-frame");
        repeat (6) applyStimulus(1'b1, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 1'b1);
        #1;
        checkOutput("midrst_rd_en", 32'(bus.rd_en), 32'd0);
        checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_out_last", 32'(bus.out_last), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_out_data", bus.out_data, 32'd0);
        applyStimulus(1'b0, 1'b1, 0, 1'b1);
        repeat (2) applyStimulus(1'b0, 1'b1, 0, 1'b0);
        clearRecords();
        wordCtr = 1000;
        applyStimulus(1'b1, 1'b1, 8, 1'b0);
        budget = 0;
        while (doneCount < 1 && budget < 100) begin
            applyStimulus(1'b1, 1'b1, 0, 1'b0);
            budget++;
        end
        checkOutput("postrst_frames", 32'(doneCount), 32'd1);
        checkOutput("postrst_count", 32'(gotData.size()), 32'd8);
        if (gotData.size() == 8) begin
            checkOutput("postrst_first", gotData[0], 32'd1000);
            checkOutput("postrst_last", 32'(gotLast[7]), 32'd1);
        end

        $display("[TB] random traffic");
        for (int k = 0; k < 500; k++) begin
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
                          (fifoQ.size() < 20) ? int'($urandom_range(0, 2)) : 0, 1'b0);
        end

        chkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
